// File: rtl/alex_pkg.sv
// -----------------------------------------------------------------------------
// alex_pkg
// Shared definitions for the Alex filter-bank selectors:
//   - default LPF band edges (Hz) and relay codes for the 7-band Alex board
//   - clog2 helper usable in parameter/localparam expressions
//   - scheduler FSM state encoding
// Packed tables are little-end-first: entry 0 sits in the least significant
// slice, so the lowest band comes last in the concatenations below.
// -----------------------------------------------------------------------------
package alex_pkg;

    localparam int ALEX_NUM_BANDS = 7;
    localparam int ALEX_LPF_W     = 7;

    // Entry k is the upper edge of band k.
    localparam logic [(ALEX_NUM_BANDS-1)*32-1:0] ALEX_LPF_EDGES = {
        32'd32000000, 32'd26000000, 32'd15000000,
        32'd8000000,  32'd4500000,  32'd2400000
    };

    // Entry b is the relay code for band b.
    localparam logic [ALEX_NUM_BANDS*ALEX_LPF_W-1:0] ALEX_LPF_CODES = {
        7'b0010000, 7'b0100000, 7'b1000000, 7'b0000001,
        7'b0000010, 7'b0000100, 7'b0001000
    };

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DECIDE,
        ST_WAIT_PTT,
        ST_SETTLE
    } sched_state_t;

endpackage

// File: rtl/relay_settle_timer.sv
// -----------------------------------------------------------------------------
// relay_settle_timer
// Down-counter that times the relay settle interval after a filter switch.
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_load   reload the counter with SETTLE_CYCLES
//   i_count  decrement while the owner sits in its settle state
//   o_done   high on the last cycle of the interval
// With i_count held high after a load, o_done rises on the SETTLE_CYCLES-th
// counting cycle, so the owner spends exactly SETTLE_CYCLES cycles settling.
// SETTLE_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module relay_settle_timer
    import alex_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 122880,
    localparam int CNT_W = (clog2(int'(SETTLE_CYCLES) + 1) < 1) ? 1 : clog2(int'(SETTLE_CYCLES) + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_count,
    output logic o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(SETTLE_CYCLES);
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count <= CNT_W'(1));

endmodule

// File: rtl/lpf_select_sched.sv
// -----------------------------------------------------------------------------
// lpf_select_sched
// Parametrised Alex low-pass filter selector. Sits between the C&C frequency
// register and the Alex relay driver.
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   frequency   tuned frequency in Hz (quasi-static)
//   ptt         transmit active, already synchronous to clock
//   LPF         relay code currently applied
//   band        index of the applied band (0 = lowest frequency)
//   busy        scan, pending switch or settle in progress
//   tx_inhibit  high while relays settle (and until the first settle after
//               reset completes)
// The band is found by a serial scan that tests one edge per cycle against a
// frequency snapshot. A change of band is then filtered by edge hysteresis,
// held off while transmitting, and followed by a settle interval.
// -----------------------------------------------------------------------------
module lpf_select_sched
    import alex_pkg::*;
#(
    parameter int NUM_BANDS = ALEX_NUM_BANDS,
    parameter int LPF_W     = ALEX_LPF_W,
    parameter logic [(NUM_BANDS-1)*32-1:0] EDGES     = ALEX_LPF_EDGES,
    parameter logic [NUM_BANDS*LPF_W-1:0]  LPF_CODES = ALEX_LPF_CODES,
    parameter int unsigned HYST_HZ       = 10000,
    parameter int unsigned SETTLE_CYCLES = 122880,
    localparam int BAND_W = (clog2(NUM_BANDS) < 1) ? 1 : clog2(NUM_BANDS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       frequency,
    input  logic              ptt,
    output logic [LPF_W-1:0]  LPF,
    output logic [BAND_W-1:0] band,
    output logic              busy,
    output logic              tx_inhibit
);

    // Tables are padded to a power of two so a BAND_W-bit index is always
    // in range; padding entries are never selected.
    localparam int                TBL_N     = 2 ** BAND_W;
    localparam logic [BAND_W-1:0] LAST_IDX  = BAND_W'(NUM_BANDS - 2);
    localparam logic [LPF_W-1:0]  LPF_RESET = LPF_CODES[LPF_W-1:0];

    logic [31:0]      w_edge    [TBL_N];
    logic [31:0]      w_edge_hi [TBL_N];   // edge + HYST_HZ, saturated
    logic [31:0]      w_edge_lo [TBL_N];   // edge - HYST_HZ, floored at 0
    logic [LPF_W-1:0] w_code    [TBL_N];

    for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
        if (gi < NUM_BANDS - 1) begin : g_edge
            // Thresholds are constants, so the 33-bit clamp costs no logic.
            localparam logic [32:0] HI_SUM = {1'b0, EDGES[gi*32 +: 32]} + 33'(HYST_HZ);
            localparam logic [32:0] LO_DIF = {1'b0, EDGES[gi*32 +: 32]} - 33'(HYST_HZ);
            assign w_edge[gi]    = EDGES[gi*32 +: 32];
            assign w_edge_hi[gi] = HI_SUM[32] ? 32'hFFFF_FFFF : HI_SUM[31:0];
            assign w_edge_lo[gi] = LO_DIF[32] ? 32'd0 : LO_DIF[31:0];
        end else begin : g_edge_pad
            assign w_edge[gi]    = 32'hFFFF_FFFF;
            assign w_edge_hi[gi] = 32'hFFFF_FFFF;
            assign w_edge_lo[gi] = 32'hFFFF_FFFF;
        end
        if (gi < NUM_BANDS) begin : g_code
            assign w_code[gi] = LPF_CODES[gi*LPF_W +: LPF_W];
        end else begin : g_code_pad
            assign w_code[gi] = LPF_RESET;
        end
    end

    sched_state_t      r_state;
    sched_state_t      w_state_next;
    logic [31:0]       r_fsnap;
    logic [BAND_W-1:0] r_idx;
    logic [BAND_W-1:0] r_raw;
    logic [BAND_W-1:0] r_band;
    logic [LPF_W-1:0]  r_lpf;
    // After reset the first scan has no snapshot yet; it spends one cycle
    // capturing frequency before testing edges.
    logic              r_need_snap;
    // Set from reset until the first settle completes: forces the first
    // decision to apply (and settle) even if the band is unchanged.
    logic              r_init;

    logic              w_scan_start;
    logic              w_apply;
    logic              w_settle_load;
    logic              w_settling;
    logic              w_settle_done;
    logic [BAND_W-1:0] w_cand;
    logic [BAND_W-1:0] w_raw_m1;
    logic [BAND_W-1:0] w_raw_p1;

    assign w_raw_m1 = r_raw - BAND_W'(1);
    assign w_raw_p1 = r_raw + BAND_W'(1);

    // Hysteresis: a band change only sticks once the snapshot is clearly past
    // the edge nearest the current band; otherwise step back toward it.
    always_comb begin
        w_cand = r_band;
        if (r_init) begin
            w_cand = r_raw;
        end else if (r_raw > r_band) begin
            w_cand = (r_fsnap > w_edge_hi[w_raw_m1]) ? r_raw : w_raw_m1;
        end else if (r_raw < r_band) begin
            w_cand = (r_fsnap <= w_edge_lo[r_raw]) ? r_raw : w_raw_p1;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_scan_start  = 1'b0;
        w_apply       = 1'b0;
        w_settle_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frequency != r_fsnap) begin
                    w_state_next = ST_SCAN;
                    w_scan_start = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!r_need_snap && (r_idx == LAST_IDX)) begin
                    w_state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (r_init || (w_cand != r_band)) begin
                    if (ptt) begin
                        w_state_next = ST_WAIT_PTT;
                    end else begin
                        w_state_next  = ST_SETTLE;
                        w_apply       = 1'b1;
                        w_settle_load = 1'b1;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_PTT: begin
                // Rescan rather than apply the stale decision: the dial may
                // have moved while transmitting.
                if (!ptt) begin
                    w_state_next = ST_SCAN;
                    w_scan_start = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_SCAN;
            r_fsnap     <= '0;
            r_idx       <= '0;
            r_raw       <= '0;
            r_band      <= '0;
            r_lpf       <= LPF_RESET;
            r_need_snap <= 1'b1;
            r_init      <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_scan_start) begin
                r_fsnap <= frequency;
                r_idx   <= '0;
                r_raw   <= '0;
            end else if (r_state == ST_SCAN) begin
                if (r_need_snap) begin
                    r_fsnap     <= frequency;
                    r_need_snap <= 1'b0;
                end else begin
                    // Strict compare: a frequency equal to an edge stays in
                    // the lower band.
                    if (r_fsnap > w_edge[r_idx]) begin
                        r_raw <= r_raw + BAND_W'(1);
                    end
                    r_idx <= r_idx + BAND_W'(1);
                end
            end
            if (w_apply) begin
                r_band <= w_cand;
                r_lpf  <= w_code[w_cand];
            end
            if ((r_state == ST_SETTLE) && w_settle_done) begin
                r_init <= 1'b0;
            end
        end
    end

    assign w_settling = (r_state == ST_SETTLE);

    relay_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_load  (w_settle_load),
        .i_count (w_settling),
        .o_done  (w_settle_done)
    );

    assign LPF        = r_lpf;
    assign band       = r_band;
    assign busy       = (r_state != ST_IDLE);
    assign tx_inhibit = w_settling || r_init;

endmodule

// File: doc/lpf_select_sched.md
Name: lpf_select_sched

Overview:
- Parametrised successor to the fixed Alex LPF decoder.
- Band edges, band count, LPF codes, hysteresis and relay settle time are all parameters.
- Finds the band with a sequential one-edge-per-cycle scan, so there is no wide parallel comparator tree.
- Adds edge hysteresis, no relay switching while PTT is asserted, and a post-switch settle interval that raises tx_inhibit. Sits between the C&C frequency register and the Alex SPI/relay driver.

Parameters:
- NUM_BANDS, 7, number of filter bands (2..16). Band 0 is the lowest frequency.
- LPF_W, 7, width of the LPF relay code.
- EDGES, {32000000,26000000,15000000,8000000,4500000,2400000}, packed (NUM_BANDS-1)x32. Entry k is the upper edge of band k, in Hz, strictly ascending.
- LPF_CODES, {0010000,0100000,1000000,0000001,0000010,0000100,0001000}, packed NUM_BANDS x LPF_W. Entry b is the relay code for band b.
- HYST_HZ, 10000, hysteresis in Hz. Must be less than half the narrowest band width.
- SETTLE_CYCLES, 122880, relay settle time in clock cycles (1 ms at 122.88 MHz).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frequency  in  32  tuned frequency in Hz, quasi-static
- ptt  in  1  transmit active (already synchronised to clock)
- LPF  out  LPF_W  relay code currently applied
- band  out  clog2(NUM_BANDS)  index of the applied band
- busy  out  1  scan, pending switch or settle in progress
- tx_inhibit  out  1  high while the relays are settling

Behaviour:
- Reset (async assert, sync deassert):
  - LPF = LPF_CODES[0], band = 0.
  - FSM enters SCAN with a forced scan; busy = 1, tx_inhibit = 1.
  - tx_inhibit stays high until the first settle interval completes.
- States: IDLE, SCAN, DECIDE, WAIT_PTT, SETTLE.
- IDLE:
  - busy = 0, tx_inhibit = 0.
  - If frequency differs from the snapshot, go to SCAN next cycle.
- SCAN:
  - On entry, snapshot frequency into fsnap; clear idx and raw.
  - Each cycle: if fsnap > EDGES[idx], raw++. Then idx++.
  - After NUM_BANDS-1 cycles, go to DECIDE.
  - Equality counts as the lower band, so frequency == edge selects the lower band.
- DECIDE (one cycle):
  - raw == band: no change.
  - raw > band: if fsnap > EDGES[raw-1] + HYST_HZ, cand = raw; else cand = raw-1.
  - raw < band: if fsnap <= EDGES[raw] - HYST_HZ, cand = raw; else cand = raw+1.
  - If cand == band, go to IDLE.
  - Otherwise: if ptt = 1, go to WAIT_PTT; if ptt = 0, apply cand and go to SETTLE.
  - Apply means LPF and band update on the transition cycle.
  - Hysteresis arithmetic is 33-bit unsigned. Sums saturate at 2^32-1; differences floor at 0.
- WAIT_PTT:
  - LPF is unchanged.
  - When ptt falls, go to SCAN (a rescan, because frequency may have moved).
- SETTLE:
  - tx_inhibit = 1; the counter runs SETTLE_CYCLES cycles.
  - Frequency changes are ignored until the end of settle.
  - At the end, go to IDLE. IDLE rescans next cycle if frequency differs from fsnap.
- Latency, frequency change to LPF update with ptt = 0: 1 (IDLE detect) + (NUM_BANDS-1) + 1 = NUM_BANDS+1 cycles.
- Frequency changing mid-SCAN: the scan completes on fsnap; the mismatch is caught in IDLE afterwards.
- ptt rising in SETTLE: no effect on the FSM. tx_inhibit is the TX path's interlock.
- reset_n asserted mid-operation: all state returns to reset values immediately; the pending switch is discarded.
- busy = 1 in every state except IDLE.

Decomposition:
- Package alex_pkg: default EDGES and LPF_CODES constants, a clog2 function, FSM state enum.
- One natural sub-module, relay_settle_timer: load/count/done down-counter parameterised by SETTLE_CYCLES.
  - Reused by the HPF selector.

Test Plan:
- Reset with frequency = 1800000 -> LPF = 0001000, band = 0, tx_inhibit high for 6+SETTLE_CYCLES+2 cycles, then busy = 0.
- frequency 1800000 -> 14200000, ptt = 0 -> LPF = 0000001, band = 3, exactly 8 cycles after the change; tx_inhibit high for SETTLE_CYCLES.
- Hysteresis: from band 3, set 8005000 -> band 3 retained; 7995000 -> band 3 retained; 7989000 -> band 2, LPF 0000010.
- Boundary: frequency = 2400000 exactly from band 1 (HYST 0 build) -> band 0; 2400001 -> band 1.
- PTT hold: ptt = 1, frequency 7100000 -> 50100000 -> LPF unchanged, busy = 1. Drop ptt -> rescan, LPF = 0010000 at ptt fall + 8 cycles.
- reset_n pulsed low mid-SETTLE -> LPF = 0001000 asynchronously; new forced scan restores the band for the current frequency.
